// File: rtl/dphy_lane_deskew.sv
// D-PHY byte-lane deskew.
// Each lane has its own small FIFO. The FIFOs absorb the difference in when
// each lane delivers its first byte. The FSM measures that first-byte skew,
// starts a lock-step pop once every lane holds data, and requests upstream
// re-alignment when the skew is too large or a FIFO overflows.
module dphy_lane_deskew #(
    parameter int DATA_LANES = 2,
    parameter int MAX_SKEW   = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    eop_i,
    input  logic [DATA_LANES*8-1:0] byte_data_i,
    input  logic [DATA_LANES-1:0]   valid_i,
    output logic [DATA_LANES*8-1:0] word_o,
    output logic                    valid_o,
    output logic                    reset_align_o,
    output logic                    skew_err_o,
    output logic [DATA_LANES*3-1:0] lane_skew_o
);

    // Two entries beyond the worst tolerated skew. The earliest lane has
    // MAX_SKEW+1 bytes queued when the last lane arrives, and it keeps
    // writing while popping starts.
    localparam int DEPTH = MAX_SKEW + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [3:0]       SKEW_SAT = 4'(MAX_SKEW + 1);
    localparam logic [3:0]       SKEW_MAX = 4'(MAX_SKEW);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ALL,
        S_STREAM,
        S_ERR
    } state_e;

    state_e state_q, state_d;

    // FSM-derived controls
    logic enter_stream;
    logic enter_err;
    logic flush;
    logic pop;

    // Per-lane FIFO status and data
    logic [DATA_LANES-1:0]   wr_req;
    logic [DATA_LANES-1:0]   fifo_full;
    logic [DATA_LANES-1:0]   fifo_empty;
    logic [DATA_LANES-1:0]   arrived_now;
    logic [DATA_LANES*8-1:0] head_data;
    logic                    overflow;

    // Skew measurement
    logic [3:0]              skew_cnt_q, skew_cnt_d;
    logic [3:0]              skew_inc;
    logic [DATA_LANES-1:0]   arrived_q, arrived_d;
    logic [DATA_LANES*3-1:0] rec_q, rec_d;
    logic [DATA_LANES*3-1:0] lane_skew_q, lane_skew_d;

    // Registered outputs
    logic [DATA_LANES*8-1:0] word_q;
    logic                    valid_q;
    logic                    reset_align_q;
    logic                    skew_err_q;

    // ERR discards all input. Everywhere else a valid byte is offered to its FIFO.
    assign wr_req      = (state_q != S_ERR) ? valid_i : '0;
    assign overflow    = |(wr_req & fifo_full);
    assign arrived_now = arrived_q | valid_i;
    // The counter stops at MAX_SKEW+1 so it can never wrap back into the legal range.
    assign skew_inc    = (skew_cnt_q >= SKEW_SAT) ? SKEW_SAT : skew_cnt_q + 4'd1;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // flop samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    // Next-state logic. Priority order: end of packet, then overflow, then per-state rules.
    always_comb begin
        // NOTE: default first so that no path through the case leaves a latch.
        state_d = state_q;
        if (eop_i) begin
            state_d = S_IDLE;
        end else if (overflow) begin
            state_d = S_ERR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (&valid_i)      state_d = S_STREAM;
                    else if (|valid_i) state_d = S_WAIT_ALL;
                end
                S_WAIT_ALL: begin
                    if (skew_inc > SKEW_MAX)  state_d = S_ERR;
                    else if (&arrived_now)    state_d = S_STREAM;
                end
                S_STREAM: state_d = S_STREAM;
                S_ERR: begin
                    if (valid_i == '0) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs: state-entry strobes, FIFO flush and lock-step pop
    always_comb begin
        enter_stream = (state_d == S_STREAM) && (state_q != S_STREAM);
        enter_err    = (state_d == S_ERR) && (state_q != S_ERR);
        flush        = eop_i || enter_err;
        pop          = (state_q == S_STREAM) && !(|fifo_empty) && !eop_i && !overflow;
    end

    // Skew measurement. Arrival offsets are recorded here and published on STREAM entry.
    always_comb begin
        skew_cnt_d  = skew_cnt_q;
        arrived_d   = arrived_q;
        rec_d       = rec_q;
        lane_skew_d = lane_skew_q;
        if ((state_q == S_IDLE) && (state_d == S_WAIT_ALL)) begin
            skew_cnt_d = '0;
            arrived_d  = valid_i;
            rec_d      = '0;
        end else if (state_q == S_WAIT_ALL) begin
            skew_cnt_d = skew_inc;
            arrived_d  = arrived_now;
            for (int i = 0; i < DATA_LANES; i++) begin
                if (valid_i[i] && !arrived_q[i]) rec_d[i*3 +: 3] = skew_inc[2:0];
            end
        end
        if (enter_stream) lane_skew_d = (state_q == S_IDLE) ? '0 : rec_d;
    end

    // Skew bookkeeping and the registered output stage
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            skew_cnt_q    <= '0;
            arrived_q     <= '0;
            rec_q         <= '0;
            lane_skew_q   <= '0;
            word_q        <= '0;
            valid_q       <= 1'b0;
            reset_align_q <= 1'b0;
            skew_err_q    <= 1'b0;
        end else begin
            skew_cnt_q    <= skew_cnt_d;
            arrived_q     <= arrived_d;
            rec_q         <= rec_d;
            lane_skew_q   <= lane_skew_d;
            if (pop) word_q <= head_data;
            valid_q       <= pop;
            reset_align_q <= flush;
            skew_err_q    <= enter_err;
        end
    end

    for (genvar g = 0; g < DATA_LANES; g++) begin : g_lane
        logic [7:0]       mem_q [DEPTH];
        logic [PTR_W-1:0] wr_ptr_q;
        logic [PTR_W-1:0] rd_ptr_q;
        logic [CNT_W-1:0] count_q;
        logic             do_wr;

        // A byte that meets a full FIFO is dropped. A flush drops the byte offered in the same cycle.
        assign do_wr                = wr_req[g] && !fifo_full[g] && !flush;
        assign fifo_full[g]         = (count_q == CNT_FULL);
        assign fifo_empty[g]        = (count_q == '0);
        assign head_data[g*8 +: 8]  = mem_q[rd_ptr_q];

        // Lane storage write port
        always_ff @(posedge clk_i) begin
            // NOTE: the storage array has no reset. The pointers and count alone
            // decide which entries are valid, so stale contents are never observed.
            if (do_wr) mem_q[wr_ptr_q] <= byte_data_i[g*8 +: 8];
        end

        // Lane pointers and occupancy. A flush empties the FIFO in one edge.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_wr) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
                if (pop)   rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(do_wr) - CNT_W'(pop);
            end
        end
    end

    assign word_o        = word_q;
    assign valid_o       = valid_q;
    assign reset_align_o = reset_align_q;
    assign skew_err_o    = skew_err_q;
    assign lane_skew_o   = lane_skew_q;

endmodule

// File: tb/tb_dphy_lane_deskew.sv
// Bench for dphy_lane_deskew: a 2-lane and a 4-lane instance driven with
// directed packets. Expected words carry the cycle they must appear in, and
// a monitor per instance compares them in order.
module tb_dphy_lane_deskew;

    typedef struct {
        int          cyc;
        logic [31:0] word;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_total;
    int   n_bad;

    exp_t exp2_q[$];
    exp_t exp4_q[$];

    // 2-lane instance signals
    logic        eop2;
    logic [15:0] data2;
    logic [1:0]  valid2;
    logic [15:0] word2_o;
    logic        valid2_o;
    logic        reset_align2_o;
    logic        skew_err2_o;
    logic [5:0]  lane_skew2_o;

    // 4-lane instance signals
    logic        eop4;
    logic [31:0] data4;
    logic [3:0]  valid4;
    logic [31:0] word4_o;
    logic        valid4_o;
    logic        reset_align4_o;
    logic        skew_err4_o;
    logic [11:0] lane_skew4_o;

    dphy_lane_deskew #(.DATA_LANES(2), .MAX_SKEW(3)) u_dut2 (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .eop_i         (eop2),
        .byte_data_i   (data2),
        .valid_i       (valid2),
        .word_o        (word2_o),
        .valid_o       (valid2_o),
        .reset_align_o (reset_align2_o),
        .skew_err_o    (skew_err2_o),
        .lane_skew_o   (lane_skew2_o)
    );

    dphy_lane_deskew #(.DATA_LANES(4), .MAX_SKEW(3)) u_dut4 (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .eop_i         (eop4),
        .byte_data_i   (data4),
        .valid_i       (valid4),
        .word_o        (word4_o),
        .valid_o       (valid4_o),
        .reset_align_o (reset_align4_o),
        .skew_err_o    (skew_err4_o),
        .lane_skew_o   (lane_skew4_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: stimulus driven just after edge N belongs to cycle N
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push2(input int c, input logic [15:0] w);
        exp_t e;
        e.cyc  = c;
        e.word = {16'h0, w};
        exp2_q.push_back(e);
    endfunction

    function automatic void push4(input int c, input logic [31:0] w);
        exp_t e;
        e.cyc  = c;
        e.word = w;
        exp4_q.push_back(e);
    endfunction

    task automatic step2(input logic [1:0] v, input logic [15:0] d, input logic e);
        valid2 = v;
        data2  = d;
        eop2   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic [3:0] v, input logic [31:0] d, input logic e);
        valid4 = v;
        data4  = d;
        eop4   = e;
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 2-lane instance: valid must match the queue head's cycle, and the word must match its value
    always @(negedge clk) begin : mon2
        exp_t e;
        logic exp_v;
        exp_v = (exp2_q.size() != 0) && (exp2_q[0].cyc == cyc);
        if (valid2_o || exp_v) begin
            check("d2_valid", 32'(valid2_o), 32'(exp_v));
            if (exp_v) begin
                e = exp2_q.pop_front();
                check("d2_word", 32'(word2_o), e.word);
            end
        end
    end

    // Monitor for the 4-lane instance
    always @(negedge clk) begin : mon4
        exp_t e;
        logic exp_v;
        exp_v = (exp4_q.size() != 0) && (exp4_q[0].cyc == cyc);
        if (valid4_o || exp_v) begin
            check("d4_valid", 32'(valid4_o), 32'(exp_v));
            if (exp_v) begin
                e = exp4_q.pop_front();
                check("d4_word", word4_o, e.word);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        cyc     = 0;
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        eop2 = 1'b0; data2 = '0; valid2 = '0;
        eop4 = 1'b0; data4 = '0; valid4 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid2", 32'(valid2_o), 32'h0);
        check("rst_word2", 32'(word2_o), 32'h0);
        check("rst_skew2", 32'(lane_skew2_o), 32'h0);
        check("rst_align2", 32'(reset_align2_o), 32'h0);
        check("rst_err2", 32'(skew_err2_o), 32'h0);
        check("rst_valid4", 32'(valid4_o), 32'h0);
        check("rst_skew4", 32'(lane_skew4_o), 32'h0);
        rst_n = 1'b1;
        while (cyc != 10) begin
            @(posedge clk);
            #1;
        end

        // Two lanes, zero skew, first bytes in cycle 10
        t = cyc;
        push2(t + 2, 16'h2211);
        push2(t + 3, 16'h4433);
        step2(2'b11, 16'h2211, 1'b0);
        step2(2'b11, 16'h4433, 1'b0);
        check("a_skew", 32'(lane_skew2_o), 32'h0);
        step2(2'b00, 16'h0, 1'b0);
        step2(2'b00, 16'h0, 1'b0);
        step2(2'b00, 16'h0, 1'b1);
        check("a_eop_align", 32'(reset_align2_o), 32'h1);
        check("a_eop_no_err", 32'(skew_err2_o), 32'h0);
        step2(2'b00, 16'h0, 1'b0);
        check("a_align_once", 32'(reset_align2_o), 32'h0);

        // Lane 1 absent for 4 cycles: skew timeout, then back to idle on eop
        step2(2'b01, 16'h00A0, 1'b0);
        step2(2'b01, 16'h00A1, 1'b0);
        step2(2'b01, 16'h00A2, 1'b0);
        step2(2'b01, 16'h00A3, 1'b0);
        check("c_no_err_yet", 32'(skew_err2_o), 32'h0);
        step2(2'b01, 16'h00A4, 1'b0);
        check("c_err_pulse", 32'(skew_err2_o), 32'h1);
        check("c_align_pulse", 32'(reset_align2_o), 32'h1);
        step2(2'b01, 16'h00A5, 1'b0);
        check("c_err_once", 32'(skew_err2_o), 32'h0);
        check("c_align_once", 32'(reset_align2_o), 32'h0);
        step2(2'b01, 16'h00A6, 1'b1);
        check("c_eop_align", 32'(reset_align2_o), 32'h1);
        check("c_eop_no_err", 32'(skew_err2_o), 32'h0);
        step2(2'b00, 16'h0, 1'b0);

        // Lane 1 late by 1, eop mid-stream with bytes queued, then a packet where lane 0 is late
        t = cyc;
        push2(t + 3, 16'h8101);
        push2(t + 8, 16'hB1C1);
        push2(t + 9, 16'hB2C2);
        step2(2'b01, 16'h0001, 1'b0);
        step2(2'b11, 16'h8102, 1'b0);
        check("d_skew_l1", 32'(lane_skew2_o), 32'h08);
        step2(2'b11, 16'h8203, 1'b0);
        step2(2'b11, 16'h8304, 1'b1);
        check("d_eop_valid_off", 32'(valid2_o), 32'h0);
        check("d_eop_align", 32'(reset_align2_o), 32'h1);
        step2(2'b00, 16'h0, 1'b0);
        step2(2'b10, 16'hB100, 1'b0);
        step2(2'b11, 16'hB2C1, 1'b0);
        check("d_skew_l0", 32'(lane_skew2_o), 32'h01);
        step2(2'b01, 16'h00C2, 1'b0);
        step2(2'b00, 16'h0, 1'b0);
        step2(2'b00, 16'h0, 1'b1);
        step2(2'b00, 16'h0, 1'b0);

        // Asynchronous reset while waiting for lane 1, then a clean zero-skew packet
        step2(2'b01, 16'h0055, 1'b0);
        step2(2'b01, 16'h0056, 1'b0);
        check("e_skew_held", 32'(lane_skew2_o), 32'h01);
        valid2 = 2'b00;
        data2  = 16'h0;
        #2;
        rst_n = 1'b0;
        #1;
        check("e_async_word", 32'(word2_o), 32'h0);
        check("e_async_valid", 32'(valid2_o), 32'h0);
        check("e_async_skew", 32'(lane_skew2_o), 32'h0);
        check("e_async_align", 32'(reset_align2_o), 32'h0);
        check("e_async_err", 32'(skew_err2_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        t = cyc;
        push2(t + 2, 16'h7766);
        push2(t + 3, 16'h7968);
        step2(2'b11, 16'h7766, 1'b0);
        step2(2'b11, 16'h7968, 1'b0);
        check("e_skew_zero", 32'(lane_skew2_o), 32'h0);
        step2(2'b00, 16'h0, 1'b0);
        step2(2'b00, 16'h0, 1'b1);
        step2(2'b00, 16'h0, 1'b0);

        // Lane 1 stops mid-stream: lane 0 fills its FIFO (depth 5), and the sixth queued write overflows
        t = cyc;
        push2(t + 2, 16'h0201);
        step2(2'b11, 16'h0201, 1'b0);
        for (int k = 0; k < 5; k++) step2(2'b01, 16'(8'h10 + k), 1'b0);
        check("f_not_full_yet", 32'(skew_err2_o), 32'h0);
        step2(2'b01, 16'h0015, 1'b0);
        check("f_ovf_err", 32'(skew_err2_o), 32'h1);
        check("f_ovf_align", 32'(reset_align2_o), 32'h1);
        step2(2'b00, 16'h0, 1'b0);
        check("f_err_once", 32'(skew_err2_o), 32'h0);
        step2(2'b00, 16'h0, 1'b0);

        // Four lanes: lane 2 is 3 cycles late, which is exactly MAX_SKEW
        t = cyc;
        push4(t + 5, 32'h40302010);
        push4(t + 6, 32'h41312111);
        push4(t + 7, 32'h42322212);
        step4(4'b1011, 32'h40002010, 1'b0);
        step4(4'b1011, 32'h41002111, 1'b0);
        step4(4'b1011, 32'h42002212, 1'b0);
        step4(4'b0100, 32'h00300000, 1'b0);
        check("b_skew4", 32'(lane_skew4_o), 32'h0C0);
        step4(4'b0100, 32'h00310000, 1'b0);
        step4(4'b0100, 32'h00320000, 1'b0);
        step4(4'b0000, 32'h0, 1'b0);
        step4(4'b0000, 32'h0, 1'b0);
        step4(4'b0000, 32'h0, 1'b1);
        check("b_eop_align4", 32'(reset_align4_o), 32'h1);
        check("b_no_err4", 32'(skew_err4_o), 32'h0);
        step4(4'b0000, 32'h0, 1'b0);

        repeat (4) step2(2'b00, 16'h0, 1'b0);
        check("d2_drain", 32'(exp2_q.size()), 32'h0);
        check("d4_drain", 32'(exp4_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
